// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receiver that feeds the async FIFO write port.
// Holds the receiver state encoding, the baud divider calculation and the counter-width helper.
// Contents: rx_state_t, calc_div(), cnt_width().
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_t;

    // wr_clk cycles per oversample tick, truncated.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_writer_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV wr_clk cycles.
// Latency: tick is combinational from the counter; clr restarts the period on the next edge.
// Ports: wr_clk, wr_reset (async, active-high), clr (sync clear), tick.
module uart_baud_tick
    import uart_rx_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic wr_clk,
    input  logic wr_reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = cnt_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge wr_clk or posedge wr_reset) begin
        if (wr_reset) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_fifo_writer.sv
// UART 8N1 (optional parity) receiver writing completed bytes into an async FIFO write port.
// Latency: wr_en/error pulses appear in the resolve cycle, one wr_clk after the stop-bit sample tick.
// Backpressure: wr_full is looked at only in the resolve cycle; a byte meeting a full FIFO is dropped and overrun_err pulses.
// Ports: wr_clk, wr_reset, rx_in, wr_full -> wr_en, wr_data, frame_err, parity_err, overrun_err, busy.
module uart_rx_fifo_writer
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 wr_clk,
    input  logic                 wr_reset,
    input  logic                 rx_in,
    input  logic                 wr_full,
    output logic                 wr_en,
    output logic [DATA_BITS-1:0] wr_data,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int DIV    = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int TICK_W = cnt_width(OVERSAMPLE);
    localparam int BIT_W  = cnt_width(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] HALF_PT  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_PT  = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);
    localparam logic              ODD      = (PARITY_ODD != 0);

    rx_state_t state, state_nxt;

    logic                 sync1, rx_s;
    logic                 tick, baud_clr, sample;
    logic [TICK_W-1:0]    tick_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_q, data_hold;
    logic                 par_bad, stop_bit, stop_done, resolve;

    // Two-flop synchronizer; idles high so reset does not look like a start edge.
    always_ff @(posedge wr_clk or posedge wr_reset) begin
        if (wr_reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx_in;
            rx_s  <= sync1;
        end
    end

    // Restart the tick phase on the start edge so sample points sit mid-bit.
    assign baud_clr = (state == ST_IDLE) && !rx_s;

    uart_baud_tick #(.DIV(DIV)) u_baud_tick (
        .wr_clk   (wr_clk),
        .wr_reset (wr_reset),
        .clr      (baud_clr),
        .tick     (tick)
    );

    // Half a bit into the start bit, a full bit for every later bit.
    assign sample = tick && (tick_cnt == ((state == ST_START) ? HALF_PT : FULL_PT));
    assign resolve = (state == ST_STOP) && stop_done;

    // State register
    always_ff @(posedge wr_clk or posedge wr_reset) begin
        if (wr_reset) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (!rx_s) state_nxt = ST_START;
            ST_START:     if (sample) state_nxt = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:      if (sample && bit_cnt == LAST_BIT)
                              state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            ST_PARITY:    if (sample) state_nxt = ST_STOP;
            ST_STOP:      if (stop_done) state_nxt = stop_bit ? ST_IDLE : ST_WAIT_HIGH;
            ST_WAIT_HIGH: if (rx_s) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: pulses only in the single resolve cycle, so they cannot exceed one cycle.
    always_comb begin
        busy        = (state != ST_IDLE);
        frame_err   = resolve && !stop_bit;
        parity_err  = resolve && par_bad;
        wr_en       = resolve && stop_bit && !par_bad && !wr_full;
        overrun_err = resolve && stop_bit && !par_bad && wr_full;
    end

    // Present the new byte during the strobe, otherwise the last byte written.
    assign wr_data = wr_en ? shift_q : data_hold;

    // Datapath: tick/bit counters, shift register, parity and stop capture.
    always_ff @(posedge wr_clk or posedge wr_reset) begin
        if (wr_reset) begin
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_q   <= '0;
            data_hold <= '0;
            par_bad   <= 1'b0;
            stop_bit  <= 1'b0;
            stop_done <= 1'b0;
        end else begin
            if (state == ST_IDLE || state == ST_WAIT_HIGH) begin
                tick_cnt <= '0;
            end else if (tick) begin
                tick_cnt <= sample ? '0 : tick_cnt + 1'b1;
            end

            if (state != ST_DATA) begin
                bit_cnt <= '0;
            end else if (sample) begin
                bit_cnt <= bit_cnt + 1'b1;
                shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};  // LSB arrives first
            end

            if (state == ST_IDLE) begin
                par_bad <= 1'b0;
            end else if (state == ST_PARITY && sample) begin
                par_bad <= (^shift_q) ^ rx_s ^ ODD;
            end

            if (state != ST_STOP) begin
                stop_done <= 1'b0;
            end else if (sample && !stop_done) begin
                stop_done <= 1'b1;
                stop_bit  <= rx_s;
            end

            if (wr_en) data_hold <= shift_q;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo_writer.sv
// Directed bench for uart_rx_fifo_writer at 16 MHz / 1 Mbaud / x16 (one tick per cycle, 16 cycles per bit).
// Instance a: no parity. Instance b: even parity. Pulses are counted on the falling clock edge.
module tb_uart_rx_fifo_writer;

    logic       wr_clk   = 1'b0;
    logic       wr_reset = 1'b0;
    logic       rx_a     = 1'b1;
    logic       rx_b     = 1'b1;
    logic       wr_full  = 1'b0;

    logic       wr_en_a, fe_a, pe_a, ov_a, busy_a;
    logic [7:0] wr_data_a;
    logic       wr_en_b, fe_b, pe_b, ov_b, busy_b;
    logic [7:0] wr_data_b;

    uart_rx_fifo_writer #(
        .CLK_FREQ(16000000), .BAUD(1000000), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)
    ) dut_a (
        .wr_clk(wr_clk), .wr_reset(wr_reset), .rx_in(rx_a), .wr_full(wr_full),
        .wr_en(wr_en_a), .wr_data(wr_data_a), .frame_err(fe_a), .parity_err(pe_a),
        .overrun_err(ov_a), .busy(busy_a)
    );

    uart_rx_fifo_writer #(
        .CLK_FREQ(16000000), .BAUD(1000000), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)
    ) dut_b (
        .wr_clk(wr_clk), .wr_reset(wr_reset), .rx_in(rx_b), .wr_full(1'b0),
        .wr_en(wr_en_b), .wr_data(wr_data_b), .frame_err(fe_b), .parity_err(pe_b),
        .overrun_err(ov_b), .busy(busy_b)
    );

    always #5 wr_clk = ~wr_clk;

    int cyc = 0;
    always @(posedge wr_clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Pulse counters and captured data, maintained only by the monitor.
    int n_wr_a = 0, n_fe_a = 0, n_pe_a = 0, n_ov_a = 0, n_busy_rise_a = 0;
    int n_wr_b = 0, n_pe_b = 0, n_fe_b = 0;
    int n_long = 0;
    int t_wr_a = 0;
    logic [7:0] got_a[$];
    logic [7:0] got_b[$];
    logic       wr_en_q = 0, fe_q = 0, pe_q = 0, ov_q = 0, busy_q = 0, wr_en_bq = 0, pe_bq = 0;

    always @(negedge wr_clk) begin
        if (wr_en_a) begin n_wr_a++; got_a.push_back(wr_data_a); t_wr_a = cyc; end
        if (fe_a) n_fe_a++;
        if (pe_a) n_pe_a++;
        if (ov_a) n_ov_a++;
        if (busy_a && !busy_q) n_busy_rise_a++;
        if (wr_en_b) begin n_wr_b++; got_b.push_back(wr_data_b); end
        if (pe_b) n_pe_b++;
        if (fe_b) n_fe_b++;
        if ((wr_en_a && wr_en_q) || (fe_a && fe_q) || (pe_a && pe_q) || (ov_a && ov_q) ||
            (wr_en_b && wr_en_bq) || (pe_b && pe_bq))
            n_long++;
        wr_en_q = wr_en_a; fe_q = fe_a; pe_q = pe_a; ov_q = ov_a; busy_q = busy_a;
        wr_en_bq = wr_en_b; pe_bq = pe_b;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_rx(input bit tgt, input logic v);
        if (tgt) rx_b = v;
        else     rx_a = v;
    endtask

    int t_fall = 0;

    // Drives one frame; the line is left at the stop-bit level on return.
    task automatic send_byte(input bit tgt, input logic [7:0] d, input logic stop_v,
                             input bit par_en, input logic par_v);
        set_rx(tgt, 1'b0);
        t_fall = cyc;
        repeat (16) @(negedge wr_clk);
        for (int i = 0; i < 8; i++) begin
            set_rx(tgt, d[i]);
            repeat (16) @(negedge wr_clk);
        end
        if (par_en) begin
            set_rx(tgt, par_v);
            repeat (16) @(negedge wr_clk);
        end
        set_rx(tgt, stop_v);
        repeat (16) @(negedge wr_clk);
    endtask

    int b_wr, b_fe, b_pe, b_ov, b_br, b_wrb, b_peb, lat;

    initial begin
        // Reset state
        #1 wr_reset = 1'b1;
        repeat (3) @(negedge wr_clk);
        check("reset_pulses", 32'({wr_en_a, fe_a, pe_a, ov_a, busy_a}), 0);
        check("reset_wr_data", 32'(wr_data_a), 0);
        wr_reset = 1'b0;
        repeat (10) @(negedge wr_clk);

        // Single frame 0xA5 plus latency
        b_wr = n_wr_a; b_fe = n_fe_a; b_pe = n_pe_a; b_ov = n_ov_a;
        send_byte(0, 8'hA5, 1'b1, 0, 1'b0);
        repeat (10) @(negedge wr_clk);
        check("a5_count", n_wr_a - b_wr, 1);
        check("a5_data", 32'(got_a[b_wr]), 32'hA5);
        check("a5_busy_idle", 32'(busy_a), 0);
        check("a5_no_err", (n_fe_a - b_fe) + (n_pe_a - b_pe) + (n_ov_a - b_ov), 0);
        lat = t_wr_a - t_fall;
        check("a5_latency_window", 32'(lat >= 153 && lat <= 157), 1);

        // Back-to-back frames without idle gap
        b_wr = n_wr_a; b_fe = n_fe_a; b_pe = n_pe_a; b_ov = n_ov_a;
        send_byte(0, 8'h00, 1'b1, 0, 1'b0);
        send_byte(0, 8'hFF, 1'b1, 0, 1'b0);
        send_byte(0, 8'h3C, 1'b1, 0, 1'b0);
        repeat (10) @(negedge wr_clk);
        check("b2b_count", n_wr_a - b_wr, 3);
        check("b2b_data0", 32'(got_a[b_wr]), 32'h00);
        check("b2b_data1", 32'(got_a[b_wr + 1]), 32'hFF);
        check("b2b_data2", 32'(got_a[b_wr + 2]), 32'h3C);
        check("b2b_no_err", (n_fe_a - b_fe) + (n_pe_a - b_pe) + (n_ov_a - b_ov), 0);

        // Framing error followed by a 40-bit break
        b_wr = n_wr_a; b_fe = n_fe_a;
        send_byte(0, 8'h5A, 1'b0, 0, 1'b0);
        repeat (40 * 16) @(negedge wr_clk);
        check("break_busy", 32'(busy_a), 1);
        check("break_fe_once", n_fe_a - b_fe, 1);
        check("break_no_wr", n_wr_a - b_wr, 0);
        rx_a = 1'b1;
        repeat (32) @(negedge wr_clk);
        check("break_idle", 32'(busy_a), 0);
        send_byte(0, 8'h11, 1'b1, 0, 1'b0);
        repeat (10) @(negedge wr_clk);
        check("after_break_count", n_wr_a - b_wr, 1);
        check("after_break_data", 32'(got_a[b_wr]), 32'h11);
        check("after_break_fe", n_fe_a - b_fe, 1);

        // Overrun: full FIFO through the whole frame
        b_wr = n_wr_a; b_ov = n_ov_a;
        wr_full = 1'b1;
        send_byte(0, 8'h77, 1'b1, 0, 1'b0);
        repeat (10) @(negedge wr_clk);
        wr_full = 1'b0;
        check("ovr_pulse", n_ov_a - b_ov, 1);
        check("ovr_no_wr", n_wr_a - b_wr, 0);
        check("ovr_data_held", 32'(wr_data_a), 32'h11);

        // Glitch shorter than half a bit: false start
        b_wr = n_wr_a; b_fe = n_fe_a; b_pe = n_pe_a; b_ov = n_ov_a; b_br = n_busy_rise_a;
        rx_a = 1'b0;
        repeat (4) @(negedge wr_clk);
        rx_a = 1'b1;
        repeat (30) @(negedge wr_clk);
        check("glitch_busy_rose", n_busy_rise_a - b_br, 1);
        check("glitch_busy_idle", 32'(busy_a), 0);
        check("glitch_no_out", (n_wr_a - b_wr) + (n_fe_a - b_fe) + (n_pe_a - b_pe) + (n_ov_a - b_ov), 0);

        // Even parity: 0x07 has three ones, so the correct parity bit is 1
        b_wrb = n_wr_b; b_peb = n_pe_b;
        send_byte(1, 8'h07, 1'b1, 1, 1'b0);
        repeat (10) @(negedge wr_clk);
        check("par_bad_pulse", n_pe_b - b_peb, 1);
        check("par_bad_no_wr", n_wr_b - b_wrb, 0);
        send_byte(1, 8'h07, 1'b1, 1, 1'b1);
        repeat (10) @(negedge wr_clk);
        check("par_good_count", n_wr_b - b_wrb, 1);
        check("par_good_data", 32'(got_b[b_wrb]), 32'h07);
        check("par_good_no_pe", n_pe_b - b_peb, 1);
        check("par_no_fe", n_fe_b, 0);

        // Reset during data bit 3
        b_wr = n_wr_a; b_fe = n_fe_a; b_pe = n_pe_a; b_ov = n_ov_a;
        rx_a = 1'b0;
        repeat (16 + 3 * 16 + 8) @(negedge wr_clk);
        check("rst_mid_busy", 32'(busy_a), 1);
        wr_reset = 1'b1;
        #1;
        check("rst_mid_outs", 32'({wr_en_a, fe_a, pe_a, ov_a, busy_a}), 0);
        check("rst_mid_data", 32'(wr_data_a), 0);
        rx_a = 1'b1;
        repeat (4) @(negedge wr_clk);
        wr_reset = 1'b0;
        repeat (200) @(negedge wr_clk);
        check("rst_mid_silent", (n_wr_a - b_wr) + (n_fe_a - b_fe) + (n_pe_a - b_pe) + (n_ov_a - b_ov), 0);
        send_byte(0, 8'hC3, 1'b1, 0, 1'b0);
        repeat (10) @(negedge wr_clk);
        check("rst_next_count", n_wr_a - b_wr, 1);
        check("rst_next_data", 32'(got_a[b_wr]), 32'hC3);

        check("pulse_width", n_long, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
